// File: rtl/md_sched_pkg.sv
// Shared encodings and constants for the md_sched multiply/divide sequencer.
package md_sched_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } mdOp_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_DIV  = 2'b10,
      S_DONE = 2'b11
   } mdState_t;

   // Wide enough to hold WIDTH=32 divide iterations and MUL_CYCLES up to 15.
   localparam int unsigned CNT_W = 6;

   function automatic logic isSignedOp(input mdOp_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/md_sched_div_iter.sv
// One radix-2 restoring divide step: shift in the next dividend bit, trial-subtract, keep or restore.
module md_sched_div_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] remIn,
   input  logic [WIDTH-1:0] quoIn,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] remOut,
   output logic [WIDTH-1:0] quoOut
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      shifted = {remIn, quoIn[WIDTH-1]};
      diff    = shifted - {1'b0, divisor};
      // A set top bit means the trial subtraction went negative: restore.
      if (diff[WIDTH]) begin
         remOut = shifted[WIDTH-1:0];
         quoOut = {quoIn[WIDTH-2:0], 1'b0};
      end else begin
         remOut = diff[WIDTH-1:0];
         quoOut = {quoIn[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the E stage; holds the pipeline until hi/lo are ready.
// Optional macro MD_EARLY_OUT_EN: divides with a zero divisor or |dividend| < |divisor| finish in two cycles.
module md_sched
   import md_sched_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MUL_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             startE,
   input  logic [1:0]       opE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic             flushE,
   output logic             stall_mdE,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hiE,
   output logic [WIDTH-1:0] loE
);

   mdState_t         state;
   mdOp_t            opReg;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] aReg;
   logic [WIDTH-1:0] bReg;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;

   logic               divSigned;
   logic [WIDTH-1:0]   bMag;
   logic [WIDTH-1:0]   stepRem;
   logic [WIDTH-1:0]   stepQuo;
   logic               earlyOut;
   logic [WIDTH-1:0]   rawQ;
   logic [WIDTH-1:0]   rawR;
   logic [WIDTH-1:0]   fixQ;
   logic [WIDTH-1:0]   fixR;
   logic [2*WIDTH-1:0] extA;
   logic [2*WIDTH-1:0] extB;
   logic [2*WIDTH-1:0] product;

   function automatic logic [WIDTH-1:0] magOf(input logic [WIDTH-1:0] v, input logic sgn);
      magOf = (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   assign stall_mdE = rst & startE & ~flushE & (state != S_DONE);
   assign busy      = (state != S_IDLE);

   md_sched_div_iter #(.WIDTH(WIDTH)) divIter (
      .remIn   (rem),
      .quoIn   (quo),
      .divisor (bMag),
      .remOut  (stepRem),
      .quoOut  (stepQuo)
   );

   // Divide result selection and sign fix-up; quo holds |dividend| in the first DIV cycle.
   always_comb begin
      divSigned = (opReg == MD_DIV);
      bMag      = magOf(bReg, divSigned);
`ifdef MD_EARLY_OUT_EN
      earlyOut  = (cnt == CNT_W'(WIDTH)) && ((bMag == '0) || (quo < bMag));
`else
      earlyOut  = 1'b0;
`endif
      rawQ = stepQuo;
      rawR = stepRem;
      if (earlyOut) begin
         rawQ = (bMag == '0) ? '1 : '0;
         rawR = quo;
      end
      fixQ = (divSigned && (aReg[WIDTH-1] ^ bReg[WIDTH-1])) ? -rawQ : rawQ;
      fixR = (divSigned && aReg[WIDTH-1]) ? -rawR : rawR;
   end

   // Low 2*WIDTH bits of the product of sign/zero-extended operands give the signed/unsigned result.
   always_comb begin
      if (isSignedOp(opReg)) begin
         extA = {{WIDTH{aReg[WIDTH-1]}}, aReg};
         extB = {{WIDTH{bReg[WIDTH-1]}}, bReg};
      end else begin
         extA = {{WIDTH{1'b0}}, aReg};
         extB = {{WIDTH{1'b0}}, bReg};
      end
      product = extA * extB;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
         opReg <= MD_MULT;
         cnt   <= '0;
         aReg  <= '0;
         bReg  <= '0;
         rem   <= '0;
         quo   <= '0;
         done  <= 1'b0;
         hiE   <= '0;
         loE   <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (startE && !flushE) begin
                  aReg  <= srcaE;
                  bReg  <= srcbE;
                  opReg <= mdOp_t'(opE);
                  rem   <= '0;
                  quo   <= magOf(srcaE, opE == MD_DIV);
                  if (opE[1]) begin
                     state <= S_DIV;
                     cnt   <= CNT_W'(WIDTH);
                  end else begin
                     state <= S_MUL;
                     cnt   <= CNT_W'(MUL_CYCLES);
                  end
               end
            end
            S_MUL: begin
               if (flushE) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     {hiE, loE} <= product;
                     done       <= 1'b1;
                     state      <= S_DONE;
                  end
               end
            end
            S_DIV: begin
               if (flushE) begin
                  state <= S_IDLE;
               end else begin
                  rem <= stepRem;
                  quo <= stepQuo;
                  cnt <= cnt - CNT_W'(1);
                  if (earlyOut || (cnt == CNT_W'(1))) begin
                     hiE   <= fixR;
                     loE   <= fixQ;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// Randomized self-checking bench for md_sched against an arithmetic reference of hi/lo and latency.
module tb_md_sched;

   localparam int unsigned W    = 32;
   localparam int unsigned MULC = 2;

   logic          clk;
   logic          rst;
   logic          startE;
   logic [1:0]    opE;
   logic [W-1:0]  srcaE;
   logic [W-1:0]  srcbE;
   logic          flushE;
   logic          stall_mdE;
   logic          busy;
   logic          done;
   logic [W-1:0]  hiE;
   logic [W-1:0]  loE;

   int            nChecks = 0;
   int            nPass   = 0;
   int            donePulses = 0;
   int            expPulses  = 0;
   logic [W-1:0]  expHi = '0;
   logic [W-1:0]  expLo = '0;
   logic [W-1:0]  gotHi;
   logic [W-1:0]  gotLo;

   md_sched #(.WIDTH(W), .MUL_CYCLES(MULC)) dut (
      .clk       (clk),
      .rst       (rst),
      .startE    (startE),
      .opE       (opE),
      .srcaE     (srcaE),
      .srcbE     (srcbE),
      .flushE    (flushE),
      .stall_mdE (stall_mdE),
      .busy      (busy),
      .done      (done),
      .hiE       (hiE),
      .loE       (loE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) donePulses++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Reference {hi,lo} straight from the arithmetic definition of each op.
   function automatic logic [63:0] refMd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      int              ia, ib;
      logic [31:0]     q, r;
      case (op)
         2'd0: begin sa = $signed(a); sb = $signed(b); return 64'(sa * sb); end
         2'd1: begin ua = a; ub = b; return ua * ub; end
         2'd3: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: begin
            if (b == 0) begin
               q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
               return {a, q};
            end
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            ia = $signed(a); ib = $signed(b);
            q = 32'(ia / ib);
            r = 32'(ia % ib);
            return {r, q};
         end
      endcase
   endfunction

   function automatic int refLat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!op[1]) return MULC + 1;
`ifdef MD_EARLY_OUT_EN
      begin
         logic [31:0] ma, mb;
         ma = (op == 2'd2 && a[31]) ? -a : a;
         mb = (op == 2'd2 && b[31]) ? -b : b;
         if (b == 0 || ma < mb) return 2;
      end
`endif
      return W + 1;
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Present one op in E (called just after a posedge) and hold it until done; leaves E empty.
   task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] exp;
      int          lat, doneAt, stallN;
      exp    = refMd(op, a, b);
      lat    = refLat(op, a, b);
      startE = 1'b1; opE = op; srcaE = a; srcbE = b;
      doneAt = -1; stallN = 0; gotHi = '0; gotLo = '0;
      for (int k = 0; k <= int'(W) + 4; k++) begin
         @(negedge clk);
         if (stall_mdE) stallN++;
         if (done && doneAt < 0) begin
            doneAt = k; gotHi = hiE; gotLo = loE;
         end
         @(posedge clk); #1;
         if (k == 0) begin
            srcaE = $urandom; srcbE = $urandom;
         end
         if (doneAt >= 0) break;
      end
      startE = 1'b0;
      expPulses++;
      chk({tag, "_lat"}, 64'(doneAt), 64'(lat));
      chk({tag, "_stall"}, 64'(stallN), 64'(lat));
      chk({tag, "_hilo"}, {gotHi, gotLo}, exp);
      expHi = exp[63:32];
      expLo = exp[31:0];
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      rst = 1'b0; startE = 1'b1; flushE = 1'b0; opE = 2'd0; srcaE = 32'd3; srcbE = 32'd4;
      idle(2);
      @(negedge clk);
      chk("rst_stall", 64'(stall_mdE), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_hilo", {hiE, loE}, 0);
      @(posedge clk); #1;
      rst = 1'b1; startE = 1'b0;
      idle(1);

      issue("divu_100_7", 2'd3, 32'd100, 32'd7);
      chk("divu_100_7_lo", 64'(gotLo), 64'd14);
      chk("divu_100_7_hi", 64'(gotHi), 64'd2);
      idle(1);
      issue("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2);
      chk("div_m7_2_const", {gotHi, gotLo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      idle(2);
      issue("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf_const", {gotHi, gotLo}, {32'd0, 32'h8000_0000});
      idle(1);
      issue("mult", 2'd0, 32'hFFFF_FFFF, 32'd2);
      chk("mult_const", {gotHi, gotLo}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
      idle(1);
      issue("multu", 2'd1, 32'hFFFF_FFFF, 32'd2);
      chk("multu_const", {gotHi, gotLo}, {32'd1, 32'hFFFF_FFFE});
      idle(1);
      issue("divu_5_0", 2'd3, 32'd5, 32'd0);
      chk("divu_5_0_const", {gotHi, gotLo}, {32'd5, 32'hFFFF_FFFF});
      idle(1);
      issue("divu_3_9", 2'd3, 32'd3, 32'd9);
      chk("divu_3_9_const", {gotHi, gotLo}, {32'd3, 32'd0});
      idle(1);

      // Flush during divide iteration 10: no done, results untouched.
      begin
         int p0;
         p0 = donePulses;
         startE = 1'b1; opE = 2'd3; srcaE = 32'hFFFF_FFF0; srcbE = 32'd3;
         idle(10);
         flushE = 1'b1;
         @(negedge clk);
         chk("flush_stall", 64'(stall_mdE), 0);
         @(posedge clk); #1;
         flushE = 1'b0; startE = 1'b0;
         @(negedge clk);
         chk("flush_busy", 64'(busy), 0);
         idle(W + 4);
         chk("flush_nodone", 64'(donePulses), 64'(p0));
         chk("flush_hilo", {hiE, loE}, {expHi, expLo});
      end

      // Reset asserted in the middle of a multiply.
      startE = 1'b1; opE = 2'd0; srcaE = 32'd7; srcbE = 32'd9;
      idle(1);
      chk("mulrst_busy_pre", 64'(busy), 1);
      rst = 1'b0;
      @(negedge clk);
      chk("mulrst_stall", 64'(stall_mdE), 0);
      @(posedge clk); #1;
      startE = 1'b0;
      @(negedge clk);
      chk("mulrst_state", {61'd0, busy, done, stall_mdE}, 0);
      chk("mulrst_hilo", {hiE, loE}, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      expHi = '0; expLo = '0;
      idle(4);

      // Back-to-back: second op is already in E when the first leaves.
      issue("b2b_divu", 2'd3, 32'd1000, 32'd33);
      issue("b2b_multu", 2'd1, 32'd12345, 32'd678);
      idle(2);

      for (int i = 0; i < 30; i++) begin
         logic [1:0]  op;
         logic [31:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = pickOperand();
         b  = pickOperand();
         issue($sformatf("rnd%0d", i), op, a, b);
         idle($urandom_range(0, 2));
         @(negedge clk);
         chk($sformatf("rnd%0d_hold", i), {hiE, loE}, {expHi, expLo});
         @(posedge clk); #1;
      end

      idle(2);
      chk("done_pulses", 64'(donePulses), 64'(expPulses));
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
